// File: rtl/rgb_to_cmyk.sv
// rgb_to_cmyk: pipelined RGB -> CMYK converter.
// K = MAX - max(R,G,B); each of C/M/Y is (Kp - chan) * MAX / Kp, computed by a
// restoring divider that produces one quotient bit per stage, MSB first.
// Pipe: input register, operand stage, COLOR_PRECISION divide stages, output
// register -> COLOR_PRECISION+2 clocks of latency, one pixel per clock.
// A valid bit travels with the data so that reset-flushed (all-zero) stages
// never reach the outputs as a bogus divide-by-zero result.
module rgb_to_cmyk #(
  parameter int COLOR_PRECISION = 8
) (
  input  logic                       i_sysclk,
  input  logic                       i_arst,
  input  logic [COLOR_PRECISION-1:0] i_R,
  input  logic [COLOR_PRECISION-1:0] i_G,
  input  logic [COLOR_PRECISION-1:0] i_B,
  output logic [COLOR_PRECISION-1:0] o_C,
  output logic [COLOR_PRECISION-1:0] o_M,
  output logic [COLOR_PRECISION-1:0] o_Y,
  output logic [COLOR_PRECISION-1:0] o_K
);

  localparam int N = COLOR_PRECISION;
  localparam logic [N-1:0]   MAX   = {N{1'b1}};
  localparam logic [2*N-1:0] MAX_W = {{N{1'b0}}, {N{1'b1}}};

  // Input register: channel 0 = R, 1 = G, 2 = B.
  logic [N-1:0] in_q [0:2];
  logic         in_vld_q;

  // Pipe stage 0 holds the operands, stages 1..N are divide steps.
  logic [N-1:0] kp_q   [0:N];
  logic [N-1:0] kp_d   [0:N];
  logic         zero_q [0:N];
  logic         zero_d [0:N];
  logic         vld_q  [0:N];
  logic         vld_d  [0:N];
  logic [N-1:0] rem_q  [0:N][0:2];   // partial remainder, always < Kp
  logic [N-1:0] rem_d  [0:N][0:2];
  logic [N-1:0] low_q  [0:N][0:2];   // numerator bits not yet shifted in
  logic [N-1:0] low_d  [0:N][0:2];
  logic [N-1:0] quo_q  [0:N][0:2];   // quotient bits collected so far
  logic [N-1:0] quo_d  [0:N][0:2];

  // Output register.
  logic [N-1:0] c_q, m_q, y_q, k_q;
  logic [N-1:0] c_d, m_d, y_d, k_d;

  // Operand preparation, divide steps and output override.
  always_comb begin
    logic [N-1:0]   kp_s;
    logic [N-1:0]   diff_s;
    logic [2*N-1:0] num_s;
    logic [N:0]     trial_s;
    logic           qbit_s;

    kp_s    = in_q[0];
    diff_s  = {N{1'b0}};
    num_s   = {(2*N){1'b0}};
    trial_s = {(N+1){1'b0}};
    qbit_s  = 1'b0;

    if (in_q[1] > kp_s) kp_s = in_q[1];
    else                kp_s = kp_s;
    if (in_q[2] > kp_s) kp_s = in_q[2];
    else                kp_s = kp_s;

    kp_d[0]   = kp_s;
    zero_d[0] = (kp_s == {N{1'b0}});
    vld_d[0]  = in_vld_q;
    for (int ch = 0; ch < 3; ch++) begin
      diff_s           = kp_s - in_q[ch];
      num_s            = {{N{1'b0}}, diff_s} * MAX_W;
      rem_d[0][ch]     = num_s[2*N-1:N];
      low_d[0][ch]     = num_s[N-1:0];
      quo_d[0][ch]     = {N{1'b0}};
    end

    for (int s = 1; s <= N; s++) begin
      kp_d[s]   = kp_q[s-1];
      zero_d[s] = zero_q[s-1];
      vld_d[s]  = vld_q[s-1];
      for (int ch = 0; ch < 3; ch++) begin
        trial_s = {rem_q[s-1][ch], low_q[s-1][ch][N-1]};
        if (trial_s >= {1'b0, kp_q[s-1]}) begin
          trial_s = trial_s - {1'b0, kp_q[s-1]};
          qbit_s  = 1'b1;
        end else begin
          qbit_s  = 1'b0;
        end
        rem_d[s][ch] = trial_s[N-1:0];
        low_d[s][ch] = {low_q[s-1][ch][N-2:0], 1'b0};
        quo_d[s][ch] = {quo_q[s-1][ch][N-2:0], qbit_s};
      end
    end

    if (!vld_q[N]) begin
      c_d = {N{1'b0}};
      m_d = {N{1'b0}};
      y_d = {N{1'b0}};
      k_d = {N{1'b0}};
    end else if (zero_q[N]) begin
      c_d = {N{1'b0}};
      m_d = {N{1'b0}};
      y_d = {N{1'b0}};
      k_d = MAX;
    end else begin
      c_d = quo_q[N][0];
      m_d = quo_q[N][1];
      y_d = quo_q[N][2];
      k_d = MAX - kp_q[N];
    end
  end

  // Pipeline registers with synchronous reset that clears every stage.
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      in_vld_q <= 1'b0;
      for (int ch = 0; ch < 3; ch++) in_q[ch] <= {N{1'b0}};
      for (int s = 0; s <= N; s++) begin
        kp_q[s]   <= {N{1'b0}};
        zero_q[s] <= 1'b0;
        vld_q[s]  <= 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
          rem_q[s][ch] <= {N{1'b0}};
          low_q[s][ch] <= {N{1'b0}};
          quo_q[s][ch] <= {N{1'b0}};
        end
      end
      c_q <= {N{1'b0}};
      m_q <= {N{1'b0}};
      y_q <= {N{1'b0}};
      k_q <= {N{1'b0}};
    end else begin
      in_vld_q <= 1'b1;
      in_q[0]  <= i_R;
      in_q[1]  <= i_G;
      in_q[2]  <= i_B;
      for (int s = 0; s <= N; s++) begin
        kp_q[s]   <= kp_d[s];
        zero_q[s] <= zero_d[s];
        vld_q[s]  <= vld_d[s];
        for (int ch = 0; ch < 3; ch++) begin
          rem_q[s][ch] <= rem_d[s][ch];
          low_q[s][ch] <= low_d[s][ch];
          quo_q[s][ch] <= quo_d[s][ch];
        end
      end
      c_q <= c_d;
      m_q <= m_d;
      y_q <= y_d;
      k_q <= k_d;
    end
  end

  assign o_C = c_q;
  assign o_M = m_q;
  assign o_Y = y_q;
  assign o_K = k_q;

endmodule

// File: tb/tb_rgb_to_cmyk.sv
// Bench for rgb_to_cmyk: an 8-bit and a 4-bit instance run side by side.
// Every edge's inputs/reset are logged; after every edge the outputs are
// compared with a history-based model: output after edge e is the formula
// applied to the sample of edge e-LAT, or zero if reset was seen at any edge
// from e-LAT to e.  Fixed vector tables and hand sequences add spot checks.
module tb_rgb_to_cmyk;

  localparam int LAT  = 10;  // 8-bit instance
  localparam int LAT4 = 6;   // 4-bit instance
  localparam int HMAX = 2048;

  logic       clk;
  logic       rst8, rst4;
  logic [7:0] r8, g8, b8;
  logic [7:0] c8, m8, y8, k8;
  logic [3:0] r4, g4, b4;
  logic [3:0] c4, m4, y4, k4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        rst8_h [HMAX];
  logic        rst4_h [HMAX];
  logic [23:0] in8_h  [HMAX];
  logic [11:0] in4_h  [HMAX];
  logic [31:0] out8_h [HMAX];
  logic [31:0] out4_h [HMAX];

  typedef struct {
    int w;
    int r, g, b;
    int c, m, y, k;
  } vec_t;

  vec_t tab [10];
  int   tab_edge [10];

  rgb_to_cmyk u_dut8 (
    .i_sysclk(clk), .i_arst(rst8),
    .i_R(r8), .i_G(g8), .i_B(b8),
    .o_C(c8), .o_M(m8), .o_Y(y8), .o_K(k8)
  );

  rgb_to_cmyk #(.COLOR_PRECISION(4)) u_dut4 (
    .i_sysclk(clk), .i_arst(rst4),
    .i_R(r4), .i_G(g4), .i_B(b4),
    .o_C(c4), .o_M(m4), .o_Y(y4), .o_K(k4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_cmyk(input int w, input int r, input int g, input int b);
    int mx, kp, c, m, y;
    mx = (1 << w) - 1;
    kp = r;
    if (g > kp) kp = g;
    if (b > kp) kp = b;
    if (kp == 0) return {8'd0, 8'd0, 8'd0, 8'(mx)};
    c = ((kp - r) * mx) / kp;
    m = ((kp - g) * mx) / kp;
    y = ((kp - b) * mx) / kp;
    return {8'(c), 8'(m), 8'(y), 8'(mx - kp)};
  endfunction

  function automatic logic [31:0] model8(input int e);
    if (e < LAT) return 32'd0;
    for (int i = e - LAT; i <= e; i++) if (rst8_h[i]) return 32'd0;
    return ref_cmyk(8, int'(in8_h[e-LAT][23:16]), int'(in8_h[e-LAT][15:8]), int'(in8_h[e-LAT][7:0]));
  endfunction

  function automatic logic [31:0] model4(input int e);
    if (e < LAT4) return 32'd0;
    for (int i = e - LAT4; i <= e; i++) if (rst4_h[i]) return 32'd0;
    return ref_cmyk(4, int'(in4_h[e-LAT4][11:8]), int'(in4_h[e-LAT4][7:4]), int'(in4_h[e-LAT4][3:0]));
  endfunction

  task automatic check(input string name, input int e, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got CMYK=%h expected %h", name, e, got, exp);
    end
  endtask

  // One clock: drive, log at the edge, sample on the falling edge, model check.
  task automatic step(input logic rs8, input int ir8, input int ig8, input int ib8,
                      input logic rs4, input int ir4, input int ig4, input int ib4);
    int e;
    rst8 = rs8; r8 = 8'(ir8); g8 = 8'(ig8); b8 = 8'(ib8);
    rst4 = rs4; r4 = 4'(ir4); g4 = 4'(ig4); b4 = 4'(ib4);
    @(posedge clk);
    e = cyc;
    rst8_h[e] = rs8;
    rst4_h[e] = rs4;
    in8_h[e]  = {r8, g8, b8};
    in4_h[e]  = {r4, g4, b4};
    @(negedge clk);
    out8_h[e] = {c8, m8, y8, k8};
    out4_h[e] = {4'd0, c4, 4'd0, m4, 4'd0, y4, 4'd0, k4};
    check("model8", e, out8_h[e], model8(e));
    check("model4", e, out4_h[e], model4(e));
    cyc++;
  endtask

  initial begin
    int e0, er;
    logic [31:0] got;

    tab[0] = '{8,   0,   0,   0,   0,   0,   0, 255};
    tab[1] = '{8, 255, 255, 255,   0,   0,   0,   0};
    tab[2] = '{8, 255,   0,   0,   0, 255, 255,   0};
    tab[3] = '{8,   0, 255,   0, 255,   0, 255,   0};
    tab[4] = '{8,   0,   0, 255, 255, 255,   0,   0};
    tab[5] = '{8, 128,  64,   0,   0, 127, 255, 127};
    tab[6] = '{8, 100, 100, 100,   0,   0,   0, 155};
    tab[7] = '{8, 200, 100,  50,   0, 127, 191,  55};
    tab[8] = '{4,  15,   0,   0,   0,  15,  15,   0};
    tab[9] = '{4,   8,   4,   0,   0,   7,  15,   7};

    // Reset for two clocks, then flush zeros through.
    step(1'b1, 0, 0, 0, 1'b1, 0, 0, 0);
    check("reset_out8", cyc - 1, out8_h[cyc-1], 32'd0);
    step(1'b1, 0, 0, 0, 1'b1, 0, 0, 0);
    e0 = cyc;
    for (int i = 0; i < 12; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    check("flush_zero8", e0 + LAT - 1, out8_h[e0+LAT-1], 32'd0);
    check("flush_black8", e0 + LAT, out8_h[e0+LAT], {8'd0, 8'd0, 8'd0, 8'd255});
    check("flush_black4", e0 + LAT4, out4_h[e0+LAT4], {8'd0, 8'd0, 8'd0, 8'd15});

    // Fixed vectors back-to-back, one per clock.
    for (int i = 0; i < 10; i++) begin
      tab_edge[i] = cyc;
      if (tab[i].w == 8) step(1'b0, tab[i].r, tab[i].g, tab[i].b, 1'b0, 0, 0, 0);
      else               step(1'b0, 0, 0, 0, 1'b0, tab[i].r, tab[i].g, tab[i].b);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (tab[i].w == 8) got = out8_h[tab_edge[i] + LAT];
      else               got = out4_h[tab_edge[i] + LAT4];
      check($sformatf("table%0d", i), tab_edge[i],
            got, {8'(tab[i].c), 8'(tab[i].m), 8'(tab[i].y), 8'(tab[i].k)});
    end

    // Random stream every cycle; ties and zeros are made more likely.
    for (int i = 0; i < 1000; i++) begin
      int ra, ga, ba;
      ra = int'($urandom_range(255));
      ga = ($urandom_range(7) == 0) ? ra : int'($urandom_range(255));
      ba = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(255));
      step(1'b0, ra, ga, ba, 1'b0,
           int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
    end

    // Reset for one clock while the pipe is full.
    er = cyc;
    step(1'b1, 10, 20, 30, 1'b1, 1, 2, 3);
    for (int i = 0; i < 20; i++)
      step(1'b0, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
           1'b0, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
    check("midrst_now", er, out8_h[er], 32'd0);
    check("midrst_hold", er + LAT, out8_h[er+LAT], 32'd0);
    check("midrst_first", er + LAT + 1, out8_h[er+LAT+1],
          ref_cmyk(8, int'(in8_h[er+1][23:16]), int'(in8_h[er+1][15:8]), int'(in8_h[er+1][7:0])));
    check("midrst4_hold", er + LAT4, out4_h[er+LAT4], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
